// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port RAM among NUM_REQ requesters.
// Zero-fills the RAM after reset, then grants up to one request per port per cycle.
module dp_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ-1:0]               i_req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    o_rsp_data,
  output logic                             o_init_done,
  output logic                             o_wrA,
  output logic [ADDR_WIDTH-1:0]            o_addrA,
  output logic [DATA_WIDTH-1:0]            o_dataA_in,
  input  logic [DATA_WIDTH-1:0]            i_dataA_out,
  output logic                             o_wrB,
  output logic [ADDR_WIDTH-1:0]            o_addrB,
  output logic [DATA_WIDTH-1:0]            o_dataB_in,
  input  logic [DATA_WIDTH-1:0]            i_dataB_out
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [CntW-1:0] InitLast = CntW'((2 ** (ADDR_WIDTH - 1)) - 1);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(NUM_REQ - 1);

  typedef enum logic [0:0] {StInit, StRun} state_t;

  state_t                r_state, w_state_next;
  logic [CntW-1:0]       r_init_cnt;
  logic                  r_init_done;
  logic [PtrW-1:0]       r_rr_ptr;
  logic                  r_rsp_a_vld, r_rsp_b_vld;
  logic [PtrW-1:0]       r_rsp_a_idx, r_rsp_b_idx;
  logic [DATA_WIDTH-1:0] r_rsp_hold [NUM_REQ];

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_rsp   [NUM_REQ];

  logic                  w_run, w_init, w_init_last;
  logic                  w_gnt_a, w_gnt_b, w_b_seen;
  logic [PtrW-1:0]       w_idx_a, w_idx_b, w_scan, w_last, w_rr_next;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_addr[g]  = i_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = i_req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign o_rsp_data[g*DATA_WIDTH +: DATA_WIDTH] = w_rsp[g];
  end

  // Outputs show their reset values for as long as rst is held.
  assign w_run       = (r_state == StRun) && !rst;
  assign w_init      = (r_state == StInit) && !rst;
  assign w_init_last = (r_init_cnt == InitLast);
  assign o_init_done = r_init_done;

  // Only the first valid requester after A is considered for B; an address match blocks B.
  always_comb begin
    w_gnt_a  = 1'b0;
    w_gnt_b  = 1'b0;
    w_b_seen = 1'b0;
    w_idx_a  = '0;
    w_idx_b  = '0;
    w_scan   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_scan = PtrW'((32'(r_rr_ptr) + i) % NUM_REQ);
      if (w_run && i_req_valid[w_scan]) begin
        if (!w_gnt_a) begin
          w_gnt_a = 1'b1;
          w_idx_a = w_scan;
        end else if (!w_b_seen) begin
          w_b_seen = 1'b1;
          if (w_addr[w_scan] != w_addr[w_idx_a]) begin
            w_gnt_b = 1'b1;
            w_idx_b = w_scan;
          end
        end
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (w_gnt_a) o_req_ready[w_idx_a] = 1'b1;
    if (w_gnt_b) o_req_ready[w_idx_b] = 1'b1;
  end

  assign w_last    = w_gnt_b ? w_idx_b : w_idx_a;
  assign w_rr_next = (w_last == PtrLast) ? '0 : w_last + 1'b1;

  always_comb begin
    o_wrA      = 1'b0;
    o_addrA    = '0;
    o_dataA_in = '0;
    o_wrB      = 1'b0;
    o_addrB    = '0;
    o_dataB_in = '0;
    if (w_init) begin
      o_wrA   = 1'b1;
      o_wrB   = 1'b1;
      o_addrA = ADDR_WIDTH'({r_init_cnt, 1'b0});
      o_addrB = ADDR_WIDTH'({r_init_cnt, 1'b1});
    end else begin
      if (w_gnt_a) begin
        o_wrA      = i_req_wr[w_idx_a];
        o_addrA    = w_addr[w_idx_a];
        o_dataA_in = w_wdata[w_idx_a];
      end
      if (w_gnt_b) begin
        o_wrB      = i_req_wr[w_idx_b];
        o_addrB    = w_addr[w_idx_b];
        o_dataB_in = w_wdata[w_idx_b];
      end
    end
  end

  // Responding lanes forward the RAM output directly; the rest hold their last value.
  always_comb begin
    o_rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) w_rsp[i] = r_rsp_hold[i];
    if (r_rsp_a_vld && !rst) begin
      o_rsp_valid[r_rsp_a_idx] = 1'b1;
      w_rsp[r_rsp_a_idx]       = i_dataA_out;
    end
    if (r_rsp_b_vld && !rst) begin
      o_rsp_valid[r_rsp_b_idx] = 1'b1;
      w_rsp[r_rsp_b_idx]       = i_dataB_out;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == StInit && w_init_last) w_state_next = StRun;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StInit;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_rr_ptr    <= '0;
      r_rsp_a_vld <= 1'b0;
      r_rsp_b_vld <= 1'b0;
      r_rsp_a_idx <= '0;
      r_rsp_b_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_a_vld <= w_gnt_a;
      r_rsp_b_vld <= w_gnt_b;
      r_rsp_a_idx <= w_idx_a;
      r_rsp_b_idx <= w_idx_b;
      if (r_state == StInit) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (w_init_last) r_init_done <= 1'b1;
      end
      if (w_gnt_a) r_rr_ptr <= w_rr_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      r_rsp_hold[i] <= rst ? '0 : w_rsp[i];
    end
  end

endmodule
